// File: rtl/mac_accumulator_s8_if.sv
// Handshake bundle between the product stream source, the accumulator and the result consumer.
`timescale 1ns/1ps
interface mac_accumulator_s8_if #(
  parameter int unsigned PROD_W = 16,
  parameter int unsigned ACC_W  = 48,
  parameter int unsigned CNT_W  = 8
) ();
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_product;
  logic              in_signed;
  logic              in_half;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic [CNT_W-1:0]  out_count;
  logic              out_overflow;

  // Source of products and sink of results.
  modport master (
    output in_valid, in_product, in_signed, in_half, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_count, out_overflow
  );

  // The accumulator itself.
  modport slave (
    input  in_valid, in_product, in_signed, in_half, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_overflow
  );
endinterface

// File: rtl/mac_accumulator_s8.sv
// Group accumulator behind the 8x8 chopped Baugh-Wooley multiplier.
// Full mode: one ACC_W lane per 16-bit product. Half mode: two ACC_W/2 lanes fed by the packed
// 8-bit sub-products, no carry between lanes. Result is held until out_ready.
// Define MAC_ACC_SATURATE_EN to clamp overflowing lanes instead of wrapping them.
`timescale 1ns/1ps
module mac_accumulator_s8 #(
  parameter int unsigned PROD_W = 16,
  parameter int unsigned ACC_W  = 48,
  parameter int unsigned CNT_W  = 8
) (
  input logic                  clk,
  input logic                  reset,
  mac_accumulator_s8_if.slave  bus
);

`ifdef MAC_ACC_SATURATE_EN
  localparam bit Saturate = 1'b1;
`else
  localparam bit Saturate = 1'b0;
`endif

  localparam int unsigned LANE_W = ACC_W / 2;
  localparam int unsigned HALF_W = PROD_W / 2;

  typedef enum logic [0:0] {StAccum, StHold} state_e;

  state_e            state_q;
  logic [ACC_W-1:0]  acc_q;
  logic [CNT_W-1:0]  count_q;
  logic              ovf_q;
  logic              signed_q;
  logic              half_q;
  logic [1:0]        clamp_q;    // lane pinned at its limit for the rest of the group
  logic [ACC_W-1:0]  out_acc_q;
  logic [CNT_W-1:0]  out_count_q;
  logic              out_ovf_q;

  logic              mode_signed, mode_half;
  logic [PROD_W-1:0] p;
  logic [ACC_W-1:0]  full_b, full_res;
  logic [ACC_W:0]    full_sum;
  logic [LANE_W-1:0] lo_a, hi_a, lo_b, hi_b, lo_res, hi_res;
  logic [LANE_W:0]   lo_sum, hi_sum;
  logic              full_ovf, lo_ovf, hi_ovf;
  logic [ACC_W-1:0]  acc_next;
  logic [CNT_W-1:0]  count_next;
  logic              ovf_next;
  logic [1:0]        clamp_next;

  assign bus.in_ready     = (state_q == StAccum);
  assign bus.out_valid    = (state_q == StHold);
  assign bus.out_acc      = out_acc_q;
  assign bus.out_count    = out_count_q;
  assign bus.out_overflow = out_ovf_q;

  // Next accumulator value for the beat on the input, with per-lane overflow and clamping.
  always_comb begin
    p           = bus.in_product;
    // The first beat of a group defines its mode; later beats reuse the latched copy.
    mode_signed = (count_q == '0) ? bus.in_signed : signed_q;
    mode_half   = (count_q == '0) ? bus.in_half   : half_q;
    clamp_next  = clamp_q;

    full_b   = mode_signed ? {{(ACC_W-PROD_W){p[PROD_W-1]}}, p} : {{(ACC_W-PROD_W){1'b0}}, p};
    full_sum = {1'b0, acc_q} + {1'b0, full_b};
    full_ovf = mode_signed ? ((acc_q[ACC_W-1] == full_b[ACC_W-1]) &&
                              (full_sum[ACC_W-1] != acc_q[ACC_W-1]))
                           : full_sum[ACC_W];

    lo_a   = acc_q[LANE_W-1:0];
    hi_a   = acc_q[ACC_W-1:LANE_W];
    lo_b   = mode_signed ? {{(LANE_W-HALF_W){p[HALF_W-1]}}, p[HALF_W-1:0]}
                         : {{(LANE_W-HALF_W){1'b0}}, p[HALF_W-1:0]};
    hi_b   = mode_signed ? {{(LANE_W-HALF_W){p[PROD_W-1]}}, p[PROD_W-1:HALF_W]}
                         : {{(LANE_W-HALF_W){1'b0}}, p[PROD_W-1:HALF_W]};
    lo_sum = {1'b0, lo_a} + {1'b0, lo_b};
    hi_sum = {1'b0, hi_a} + {1'b0, hi_b};
    lo_ovf = mode_signed ? ((lo_a[LANE_W-1] == lo_b[LANE_W-1]) &&
                            (lo_sum[LANE_W-1] != lo_a[LANE_W-1]))
                         : lo_sum[LANE_W];
    hi_ovf = mode_signed ? ((hi_a[LANE_W-1] == hi_b[LANE_W-1]) &&
                            (hi_sum[LANE_W-1] != hi_a[LANE_W-1]))
                         : hi_sum[LANE_W];

    full_res = full_sum[ACC_W-1:0];
    lo_res   = lo_sum[LANE_W-1:0];
    hi_res   = hi_sum[LANE_W-1:0];
    // Clamp direction follows the addend sign: signed overflow only happens with equal signs.
    if (Saturate) begin
      if (clamp_q[0]) begin
        full_res = acc_q;
        lo_res   = lo_a;
      end else if (mode_half && lo_ovf) begin
        lo_res        = !mode_signed ? '1 : (lo_b[LANE_W-1] ? {1'b1, {(LANE_W-1){1'b0}}}
                                                           : {1'b0, {(LANE_W-1){1'b1}}});
        clamp_next[0] = 1'b1;
      end else if (!mode_half && full_ovf) begin
        full_res      = !mode_signed ? '1 : (full_b[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                                            : {1'b0, {(ACC_W-1){1'b1}}});
        clamp_next[0] = 1'b1;
      end
      if (clamp_q[1]) begin
        hi_res = hi_a;
      end else if (mode_half && hi_ovf) begin
        hi_res        = !mode_signed ? '1 : (hi_b[LANE_W-1] ? {1'b1, {(LANE_W-1){1'b0}}}
                                                           : {1'b0, {(LANE_W-1){1'b1}}});
        clamp_next[1] = 1'b1;
      end
    end

    acc_next   = mode_half ? {hi_res, lo_res} : full_res;
    count_next = (count_q == '1) ? count_q : count_q + 1'b1;
    ovf_next   = ovf_q | (mode_half ? (lo_ovf | hi_ovf) : full_ovf);
  end

  // Control FSM with registered result; the accumulator is cleared as the result is captured
  // since no beat can enter while the result is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StAccum;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      signed_q    <= 1'b0;
      half_q      <= 1'b0;
      clamp_q     <= '0;
      out_acc_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StAccum: begin
          if (bus.in_valid) begin
            if (bus.in_last) begin
              out_acc_q   <= acc_next;
              out_count_q <= count_next;
              out_ovf_q   <= ovf_next;
              acc_q       <= '0;
              count_q     <= '0;
              ovf_q       <= 1'b0;
              clamp_q     <= '0;
              state_q     <= StHold;
            end else begin
              acc_q   <= acc_next;
              count_q <= count_next;
              ovf_q   <= ovf_next;
              clamp_q <= clamp_next;
              if (count_q == '0) begin
                signed_q <= bus.in_signed;
                half_q   <= bus.in_half;
              end
            end
          end
        end
        StHold: begin
          if (bus.out_ready) state_q <= StAccum;
        end
        default: state_q <= StAccum;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_accumulator_s8.sv
// Scoreboard bench for mac_accumulator_s8: a 48-bit instance for the main cases and an 18-bit
// instance for overflow. Honours MAC_ACC_SATURATE_EN for the overflow expectations.
`timescale 1ns/1ps
module tb_mac_accumulator_s8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mac_accumulator_s8_if #(.PROD_W(16), .ACC_W(48), .CNT_W(8)) bus ();
  mac_accumulator_s8_if #(.PROD_W(16), .ACC_W(18), .CNT_W(8)) bus18 ();

  mac_accumulator_s8 #(.PROD_W(16), .ACC_W(48), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  mac_accumulator_s8 #(.PROD_W(16), .ACC_W(18), .CNT_W(8)) dut18 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus18.slave)
  );

  typedef struct {
    logic [47:0] acc;
    logic [7:0]  cnt;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  exp_t sb18[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic expect48(input logic [47:0] a, input logic [7:0] c, input logic o);
    exp_t e;
    e.acc = a; e.cnt = c; e.ovf = o;
    sb.push_back(e);
  endtask

  task automatic expect18(input logic [17:0] a, input logic [7:0] c, input logic o);
    exp_t e;
    e.acc = {30'b0, a}; e.cnt = c; e.ovf = o;
    sb18.push_back(e);
  endtask

  // Monitors: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (!reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL unexpected48: got acc %0h, want no result", bus.out_acc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("acc48", {16'b0, bus.out_acc}, {16'b0, e.acc});
        check("count48", {56'b0, bus.out_count}, {56'b0, e.cnt});
        check("ovf48", {63'b0, bus.out_overflow}, {63'b0, e.ovf});
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && bus18.out_valid === 1'b1 && bus18.out_ready === 1'b1) begin
      if (sb18.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL unexpected18: got acc %0h, want no result", bus18.out_acc);
      end else begin
        exp_t e;
        e = sb18.pop_front();
        check("acc18", {46'b0, bus18.out_acc}, {16'b0, e.acc});
        check("count18", {56'b0, bus18.out_count}, {56'b0, e.cnt});
        check("ovf18", {63'b0, bus18.out_overflow}, {63'b0, e.ovf});
      end
    end
  end

  // Drivers are entered 1 ns after a rising edge and return at the same phase.
  task automatic send(input logic [15:0] p, input logic s, input logic h, input logic l);
    int n;
    bit ok;
    n = 0; ok = 1'b0;
    bus.in_valid = 1'b1; bus.in_product = p; bus.in_signed = s; bus.in_half = h;
    bus.in_last = l;
    while (!ok && n < 50) begin
      @(negedge clk); ok = bus.in_ready;
      @(posedge clk); #1; n++;
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      n_vec++; n_miss++;
      $display("FAIL send48: got no in_ready in %0d cycles, want acceptance", n);
    end
  endtask

  task automatic send18(input logic [15:0] p, input logic s, input logic h, input logic l);
    int n;
    bit ok;
    n = 0; ok = 1'b0;
    bus18.in_valid = 1'b1; bus18.in_product = p; bus18.in_signed = s; bus18.in_half = h;
    bus18.in_last = l;
    while (!ok && n < 50) begin
      @(negedge clk); ok = bus18.in_ready;
      @(posedge clk); #1; n++;
    end
    bus18.in_valid = 1'b0;
    if (!ok) begin
      n_vec++; n_miss++;
      $display("FAIL send18: got no in_ready in %0d cycles, want acceptance", n);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || sb18.size() != 0) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("drain_pending", 64'(sb.size() + sb18.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] exp_ovf_full;
    logic [8:0]  lane_hi;
    logic [8:0]  lane_lo;

    bus.in_valid = 1'b0; bus.in_product = '0; bus.in_signed = 1'b0; bus.in_half = 1'b0;
    bus.in_last = 1'b0; bus.out_ready = 1'b1;
    bus18.in_valid = 1'b0; bus18.in_product = '0; bus18.in_signed = 1'b0;
    bus18.in_half = 1'b0; bus18.in_last = 1'b0; bus18.out_ready = 1'b1;

    // T1 reset state
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_in_ready", {63'b0, bus.in_ready}, 64'd1);
    check("rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
    check("rst_out_acc", {16'b0, bus.out_acc}, 64'd0);
    check("rst_out_count", {56'b0, bus.out_count}, 64'd0);
    check("rst_out_ovf", {63'b0, bus.out_overflow}, 64'd0);

    // T2 full signed: -6 + 10 + 3
    expect48(48'd7, 8'd3, 1'b0);
    send(16'hFFFA, 1'b1, 1'b0, 1'b0);
    send(16'h000A, 1'b1, 1'b0, 1'b0);
    send(16'h0003, 1'b1, 1'b0, 1'b1);
    drain();

    // Mode latch: second beat's signed/half flags must be ignored -> 5 + 0xFFFF unsigned
    expect48(48'h10004, 8'd2, 1'b0);
    send(16'h0005, 1'b0, 1'b0, 1'b0);
    send(16'hFFFF, 1'b1, 1'b1, 1'b1);
    drain();

    // T3 half unsigned, held under backpressure (T4)
    bus.out_ready = 1'b0;
    expect48({24'd7, 24'd5}, 8'd3, 1'b0);
    send(16'h0302, 1'b0, 1'b1, 1'b0);
    send(16'h0302, 1'b0, 1'b1, 1'b0);
    send(16'h0101, 1'b0, 1'b1, 1'b1);
    bus.in_valid = 1'b1; bus.in_product = 16'h0100; bus.in_last = 1'b1;
    bus.in_signed = 1'b0; bus.in_half = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("hold_in_ready", {63'b0, bus.in_ready}, 64'd0);
      check("hold_out_valid", {63'b0, bus.out_valid}, 64'd1);
      check("hold_out_acc", {16'b0, bus.out_acc}, {40'b0, 24'd7, 24'd5});
    end
    // Handshake with in_valid still high: that beat must not be taken
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    expect48(48'd4, 8'd1, 1'b0);
    send(16'h0004, 1'b0, 1'b0, 1'b1);
    drain();

    // T5 unsigned full overflow on 18-bit: 5*0xFFFF = 0x4FFFB
`ifdef MAC_ACC_SATURATE_EN
    exp_ovf_full = 18'h3FFFF;
`else
    exp_ovf_full = 18'h0FFFB;
`endif
    expect18(exp_ovf_full, 8'd5, 1'b1);
    for (int i = 0; i < 5; i++) send18(16'hFFFF, 1'b0, 1'b0, (i == 4));
    drain();

    // Signed half overflow on 9-bit lanes: lower 3*(-128), upper 3*127, both overflow
`ifdef MAC_ACC_SATURATE_EN
    lane_hi = 9'h0FF; lane_lo = 9'h100;
`else
    lane_hi = 9'h17D; lane_lo = 9'h080;
`endif
    expect18({lane_hi, lane_lo}, 8'd3, 1'b1);
    for (int i = 0; i < 3; i++) send18(16'h7F80, 1'b1, 1'b1, (i == 2));
    drain();

    // Count saturation: 259 beats of 1
    expect48(48'd259, 8'd255, 1'b0);
    for (int i = 0; i < 259; i++) send(16'h0001, 1'b0, 1'b0, (i == 258));
    drain();

    // T6 reset mid-group
    send(16'h0010, 1'b0, 1'b0, 1'b0);
    send(16'h0010, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_in_ready", {63'b0, bus.in_ready}, 64'd1);
    expect48(48'd4, 8'd1, 1'b0);
    send(16'h0004, 1'b0, 1'b0, 1'b1);
    drain();

    // Reset while holding a result discards it
    bus.out_ready = 1'b0;
    send(16'h0009, 1'b0, 1'b0, 1'b1);
    check("hold_before_rst", {63'b0, bus.out_valid}, 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("holdrst_out_valid", {63'b0, bus.out_valid}, 64'd0);
    check("holdrst_out_acc", {16'b0, bus.out_acc}, 64'd0);
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
